// File: rtl/seven_seg_mux_ctrl_if.sv
// Write port and display outputs of the multiplexed seven-segment controller.
interface seven_seg_mux_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DATA_W     = 16
);
  logic                  wr_en;
  logic [DATA_W-1:0]     wr_data;
  logic                  wr_hex;
  logic                  wr_blank;
  logic                  busy;
  logic [NUM_DIGITS-1:0] an;
  logic [0:6]            seg;
  logic                  dp;

  modport master (output wr_en, wr_data, wr_hex, wr_blank, input busy, an, seg, dp);
  modport slave  (input wr_en, wr_data, wr_hex, wr_blank, output busy, an, seg, dp);
endinterface

// File: rtl/seven_seg_mux_ctrl.sv
// Bus-writable multiplexed seven-segment controller: hex writes commit at once,
// decimal writes run a sequential shift-add-3 conversion before an atomic commit.
module seven_seg_mux_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 18
) (
  input logic                clk,
  input logic                rstn,
  seven_seg_mux_ctrl_if.slave bus
);
  // state    | meaning
  // S_IDLE   | ready for a write
  // S_CONV   | one shift-add-3 iteration per cycle until cnt_q hits 0
  // S_COMMIT | copy BCD result into the displayed digit registers
  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  localparam int BCD_DIGITS = (3 * DATA_W) / 10 + 1;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int EXT_N      = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
  localparam int EXT_W      = 4 * EXT_N;
  localparam int DIG_W      = 4 * NUM_DIGITS;
  localparam int CNT_W      = $clog2(DATA_W + 1);
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_W-1:0]      bin_q;
  logic [BCD_W-1:0]       bcd_q;
  logic                   blank_pend_q;
  logic                   busy_q;
  logic [DIG_W-1:0]       dig_q;
  logic                   ovf_q;
  logic                   blank_q;
  logic [REFRESH_DIV-1:0] refr_q;
  logic [IDX_W-1:0]       idx_q;
  logic [NUM_DIGITS-1:0]  an_q;
  logic [0:6]             seg_q;

  logic [BCD_W-1:0]       bcd_adj, bcd_d;
  logic [EXT_W-1:0]       hex_ext, bcd_ext;
  logic                   hex_ovf, bcd_ovf;
  logic [NUM_DIGITS-1:0]  lit;
  logic                   seen;
  logic [NUM_DIGITS-1:0]  an_d;
  logic [0:6]             seg_d;

  function automatic logic [0:6] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_d   = (bcd_adj << 1) | BCD_W'(bin_q[DATA_W-1]);
    hex_ext = EXT_W'(bus.wr_data);
    bcd_ext = EXT_W'(bcd_q);
    hex_ovf = |(hex_ext >> DIG_W);
    bcd_ovf = |(bcd_ext >> DIG_W);
  end

  // Leading-zero blanking: a digit stays lit once any digit at or above it is nonzero.
  always_comb begin
    lit  = '1;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      seen = seen | (dig_q[4*i +: 4] != 4'd0);
      if (blank_q && !ovf_q && !seen) lit[i] = 1'b0;
    end
    an_d = '1;
    if (lit[idx_q]) an_d[idx_q] = 1'b0;
    seg_d = ovf_q ? 7'b1111110 : glyph(dig_q[4*idx_q +: 4]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bin_q        <= '0;
      bcd_q        <= '0;
      blank_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      dig_q        <= '0;
      ovf_q        <= 1'b0;
      blank_q      <= 1'b0;
      refr_q       <= '0;
      idx_q        <= '0;
      an_q         <= '1;
      seg_q        <= 7'b1111111;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.wr_en) begin
            if (bus.wr_hex) begin
              dig_q   <= hex_ext[DIG_W-1:0];
              ovf_q   <= hex_ovf;
              blank_q <= bus.wr_blank;
            end else begin
              state_q      <= S_CONV;
              busy_q       <= 1'b1;
              bin_q        <= bus.wr_data;
              bcd_q        <= '0;
              cnt_q        <= CNT_W'(DATA_W);
              blank_pend_q <= bus.wr_blank;
            end
          end
        end
        S_CONV: begin
          if (cnt_q == '0) begin
            state_q <= S_COMMIT;
          end else begin
            bcd_q <= bcd_d;
            bin_q <= bin_q << 1;
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_COMMIT: begin
          dig_q   <= bcd_ext[DIG_W-1:0];
          ovf_q   <= bcd_ovf;
          blank_q <= blank_pend_q;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      refr_q <= refr_q + 1'b1;
      if (refr_q == '1) begin
        idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.dp   = 1'b1;
endmodule

// File: tb/tb_seven_seg_mux_ctrl.sv
// Directed bench: stimulus pushes expected display frames, a monitor scans the
// multiplexed outputs over a full refresh round and checks each digit slot.
module tb_seven_seg_mux_ctrl;
  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010,
                         G3 = 7'b0000110, G4 = 7'b1001100, G7 = 7'b0001111,
                         GB = 7'b1100000, GE = 7'b0110000, GF = 7'b0111000,
                         GDASH = 7'b1111110;

  typedef struct {
    string           name;
    logic [3:0][6:0] seg;
    logic [3:0]      lit;
  } frame_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_busy = 1'b0;
  frame_t sb_q[$];
  frame_t fr;

  seven_seg_mux_ctrl_if #(.NUM_DIGITS(4), .DATA_W(16)) bus ();

  seven_seg_mux_ctrl #(.NUM_DIGITS(4), .DATA_W(16), .REFRESH_DIV(2)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic frame_t mk(input string name, input logic [6:0] s3, s2, s1, s0,
                                input logic [3:0] lit);
    frame_t f;
    f.name = name;
    f.seg[3] = s3; f.seg[2] = s2; f.seg[1] = s1; f.seg[0] = s0;
    f.lit = lit;
    return f;
  endfunction

  task automatic push_and_wait(input frame_t f);
    int guard;
    sb_q.push_back(f);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((sb_q.size() != 0 || mon_busy) && guard < 100);
    chk({f.name, "_scan_done"}, 32'(sb_q.size() == 0 && !mon_busy), 32'd1);
  endtask

  task automatic write(input logic [15:0] d, input logic hex, input logic blank);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_data = d; bus.wr_hex = hex; bus.wr_blank = blank;
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
  endtask

  task automatic dec_write(input string name, input logic [15:0] d, input logic blank,
                           input bit chk_busy);
    write(d, 1'b0, blank);
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      if (chk_busy && (k == 1 || k == 17)) chk({name, "_busy_hi"}, 32'(bus.busy), 32'd1);
      if (k == 18) chk({name, "_busy_lo_commit"}, 32'(bus.busy), 32'd0);
    end
  endtask

  // Monitor: one expected frame per full scan of 20 cycles (refresh round is 16).
  initial begin
    logic [3:0] seen, bad;
    bit multi;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        fr = sb_q.pop_front();
        mon_busy = 1'b1;
        seen = '0; bad = '0; multi = 1'b0;
        repeat (20) begin
          @(negedge clk);
          if ($countones(~bus.an) > 1) multi = 1'b1;
          for (int i = 0; i < 4; i++) begin
            if (bus.an[i] == 1'b0) begin
              seen[i] = 1'b1;
              if (bus.seg !== fr.seg[i]) bad[i] = 1'b1;
            end
          end
        end
        for (int i = 0; i < 4; i++) begin
          n_tests++;
          if (fr.lit[i] && (!seen[i] || bad[i])) begin
            n_fail++;
            $display("FAIL %s digit%0d: seen=%0b wrong_glyph=%0b required glyph %b", fr.name, i,
                     seen[i], bad[i], fr.seg[i]);
          end else if (!fr.lit[i] && seen[i]) begin
            n_fail++;
            $display("FAIL %s digit%0d: anode went low, required blanked", fr.name, i);
          end
        end
        n_tests++;
        if (multi) begin
          n_fail++;
          $display("FAIL %s one_hot: several anodes low at once, required at most one", fr.name);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.wr_hex = 1'b0; bus.wr_blank = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_seg", 32'(bus.seg), 32'h7F);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_dp", 32'(bus.dp), 32'd1);

    rstn = 1'b1;
    @(posedge clk); #1 chk("scan_slot0", 32'(bus.an), 32'hE);
    chk("scan_slot0_seg", 32'(bus.seg), 32'(G0));
    repeat (4) @(posedge clk); #1 chk("scan_slot1", 32'(bus.an), 32'hD);
    repeat (4) @(posedge clk); #1 chk("scan_slot2", 32'(bus.an), 32'hB);
    repeat (4) @(posedge clk); #1 chk("scan_slot3", 32'(bus.an), 32'h7);
    push_and_wait(mk("reset_zeros", G0, G0, G0, G0, 4'b1111));

    dec_write("dec1234", 16'd1234, 1'b0, 1'b1);
    push_and_wait(mk("dec1234", G1, G2, G3, G4, 4'b1111));

    write(16'hBEEF, 1'b1, 1'b0);
    chk("hex_busy_edge0", 32'(bus.busy), 32'd0);
    @(posedge clk); #1 chk("hex_busy_edge1", 32'(bus.busy), 32'd0);
    push_and_wait(mk("hexBEEF", GB, GE, GE, GF, 4'b1111));

    dec_write("dec65535", 16'd65535, 1'b0, 1'b0);
    push_and_wait(mk("ovf65535", GDASH, GDASH, GDASH, GDASH, 4'b1111));

    dec_write("dec7b", 16'd7, 1'b1, 1'b0);
    push_and_wait(mk("blank7", G0, G0, G0, G7, 4'b0001));

    dec_write("dec0b", 16'd0, 1'b1, 1'b0);
    push_and_wait(mk("blank0", G0, G0, G0, G0, 4'b0001));

    // Second write lands mid-conversion and must be dropped.
    write(16'd1111, 1'b0, 1'b0);
    for (int k = 1; k <= 18; k++) begin
      if (k == 5) begin bus.wr_en = 1'b1; bus.wr_data = 16'd2222; end
      @(posedge clk); #1;
      bus.wr_en = 1'b0;
      if (k == 18) chk("drop_busy_lo_commit", 32'(bus.busy), 32'd0);
    end
    push_and_wait(mk("drop2222", G1, G1, G1, G1, 4'b1111));
    @(posedge clk); #1 chk("drop_no_restart", 32'(bus.busy), 32'd0);

    write(16'd9999, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_an", 32'(bus.an), 32'hF);
    chk("midrst_seg", 32'(bus.seg), 32'h7F);
    @(negedge clk); rstn = 1'b1;

    dec_write("dec42", 16'd42, 1'b0, 1'b1);
    push_and_wait(mk("dec0042", G0, G0, G4, G2, 4'b1111));
    dec_write("dec42b", 16'd42, 1'b1, 1'b0);
    push_and_wait(mk("blank42", G0, G0, G4, G2, 4'b0011));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
